// File: rtl/burst_mem_responder_if.sv
// ============================================================================
// Module      : burst_mem_responder_if
// Description : Burst write/read handshake bundle between an initiator and the
//               burst memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface burst_mem_responder_if #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28
);
  logic                      wr_burst_req;
  logic [9:0]                wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
  logic [DDR_DATA_WIDTH-1:0] wr_burst_data;
  logic                      wr_burst_data_req;
  logic                      wr_burst_finish;

  logic                      rd_burst_req;
  logic [9:0]                rd_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic [DDR_DATA_WIDTH-1:0] rd_burst_data;
  logic                      rd_burst_data_valid;
  logic                      rd_burst_finish;

  logic                      busy;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    input  busy
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data, rd_burst_data_valid, rd_burst_finish,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/burst_mem_responder.sv
// ============================================================================
// Module      : burst_mem_responder
// Description : Burst memory responder: services level-held write/read burst
//               requests against an internal 2**MEM_AW-beat storage array.
//               Optional macro BURST_RESP_STALL_EN inserts one stall cycle
//               after every 4th accepted write beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_mem_responder #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_AW         = 10
) (
  input  wire logic            mem_clk,
  input  wire logic            rst,
  burst_mem_responder_if.slave bus
);

  // Narrow bus addresses are zero-extended into the storage address space.
  localparam int c_ADDR_USE = (MEM_AW < DDR_ADDR_WIDTH) ? MEM_AW : DDR_ADDR_WIDTH;
  localparam int c_DEPTH    = 2 ** MEM_AW;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_BURST = 3'd1,
    S_WR_END   = 3'd2,
    S_RD_ADDR  = 3'd3,
    S_RD_BURST = 3'd4,
    S_RD_END   = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [9:0]                r_cnt;
  logic [9:0]                w_cnt_nxt;
  logic [9:0]                r_len;
  logic [9:0]                w_len_nxt;
  logic [MEM_AW-1:0]         r_start;
  logic [MEM_AW-1:0]         w_start_nxt;
  logic [MEM_AW-1:0]         w_addr;
  logic [MEM_AW-1:0]         w_wr_start;
  logic [MEM_AW-1:0]         w_rd_start;
  logic                      w_wr_en;
  logic                      w_rd_issue;
  logic [DDR_DATA_WIDTH-1:0] r_rd_data;
  logic                      r_rd_valid;
  logic [DDR_DATA_WIDTH-1:0] r_mem [c_DEPTH];

`ifdef BURST_RESP_STALL_EN
  logic [1:0]                r_grp;
  logic [1:0]                w_grp_nxt;
  logic                      r_stall;
  logic                      w_stall_nxt;
`endif

  assign w_wr_start = MEM_AW'(bus.wr_burst_addr[c_ADDR_USE-1:0]);
  assign w_rd_start = MEM_AW'(bus.rd_burst_addr[c_ADDR_USE-1:0]);
  assign w_addr     = r_start + MEM_AW'(r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_start_nxt = r_start;
    w_wr_en     = 1'b0;
    w_rd_issue  = 1'b0;
`ifdef BURST_RESP_STALL_EN
    w_grp_nxt   = r_grp;
    w_stall_nxt = r_stall;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef BURST_RESP_STALL_EN
        w_grp_nxt   = 2'd0;
        w_stall_nxt = 1'b0;
`endif
        w_cnt_nxt = 10'd0;
        if (bus.wr_burst_req) begin
          w_start_nxt = w_wr_start;
          w_len_nxt   = bus.wr_burst_len;
          w_state_nxt = (bus.wr_burst_len == 10'd0) ? S_WR_END : S_WR_BURST;
        end else if (bus.rd_burst_req) begin
          w_start_nxt = w_rd_start;
          w_len_nxt   = bus.rd_burst_len;
          w_state_nxt = (bus.rd_burst_len == 10'd0) ? S_RD_END : S_RD_ADDR;
        end
      end
      S_WR_BURST: begin
`ifdef BURST_RESP_STALL_EN
        if (r_stall) begin
          w_stall_nxt = 1'b0;
        end else begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + 10'd1;
          w_grp_nxt = r_grp + 2'd1;
          if (r_cnt == r_len - 10'd1) begin
            w_state_nxt = S_WR_END;
          end else if (r_grp == 2'd3) begin
            w_stall_nxt = 1'b1;
          end
        end
`else
        w_wr_en   = 1'b1;
        w_cnt_nxt = r_cnt + 10'd1;
        if (r_cnt == r_len - 10'd1) begin
          w_state_nxt = S_WR_END;
        end
`endif
      end
      S_WR_END: begin
        w_state_nxt = S_IDLE;
      end
      S_RD_ADDR: begin
        w_rd_issue  = 1'b1;
        w_cnt_nxt   = r_cnt + 10'd1;
        w_state_nxt = S_RD_BURST;
      end
      // Once every address is issued, this state lingers one cycle for the last beat.
      S_RD_BURST: begin
        if (r_cnt != r_len) begin
          w_rd_issue = 1'b1;
          w_cnt_nxt  = r_cnt + 10'd1;
        end else begin
          w_state_nxt = S_RD_END;
        end
      end
      S_RD_END: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 10'd0;
      r_len      <= 10'd0;
      r_start    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
`ifdef BURST_RESP_STALL_EN
      r_grp      <= 2'd0;
      r_stall    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_start    <= w_start_nxt;
      r_rd_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_data <= r_mem[w_addr];
      end
`ifdef BURST_RESP_STALL_EN
      r_grp      <= w_grp_nxt;
      r_stall    <= w_stall_nxt;
`endif
    end
  end

  // Storage is deliberately not reset so contents survive a mid-burst abort.
  always_ff @(posedge mem_clk) begin
    if (w_wr_en) begin
      r_mem[w_addr] <= bus.wr_burst_data;
    end
  end

  assign bus.wr_burst_data_req   = w_wr_en;
  assign bus.wr_burst_finish     = (r_state == S_WR_END);
  assign bus.rd_burst_finish     = (r_state == S_RD_END);
  assign bus.rd_burst_data       = r_rd_data;
  assign bus.rd_burst_data_valid = r_rd_valid;
  assign bus.busy                = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
// ============================================================================
// Module      : tb_burst_mem_responder
// Description : Directed scoreboard bench for burst_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_burst_mem_responder;

  logic mem_clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [127:0] model [0:1023];
  logic [127:0] sb_q [$];

  burst_mem_responder_if #(.DDR_DATA_WIDTH(128), .DDR_ADDR_WIDTH(28)) bus ();

  burst_mem_responder #(
    .DDR_DATA_WIDTH(128),
    .DDR_ADDR_WIDTH(28),
    .MEM_AW        (10)
  ) dut (
    .mem_clk(mem_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_write(input logic [27:0] addr, input int len, input logic [127:0] base,
                           input string tag);
    int cyc, k, nreq, first, last, fin, nval, span, a;
    cyc = 0; k = 0; nreq = 0; first = -1; last = -1; fin = -1; nval = 0;
    a = int'(addr[9:0]);
    bus.wr_burst_addr = addr;
    bus.wr_burst_len  = 10'(len);
    bus.wr_burst_data = base;
    bus.wr_burst_req  = 1'b1;
    while (fin < 0 && cyc < 3000) begin
      @(negedge mem_clk);
      cyc++;
      if (cyc == 1) chk({tag, "_idle"}, bus.busy, 0);
      if (bus.rd_burst_data_valid) nval++;
      if (bus.wr_burst_finish) begin
        fin = cyc;
        chk({tag, "_fin_excl"}, bus.wr_burst_data_req, 0);
      end
      if (bus.wr_burst_data_req) begin
        nreq++;
        if (first < 0) first = cyc;
        last = cyc;
        model[(a + k) % 1024] = base + 128'(k);
        k++;
      end
      @(posedge mem_clk);
      #1;
      bus.wr_burst_data = base + 128'(k);
    end
    bus.wr_burst_req = 1'b0;
    span = len;
`ifdef BURST_RESP_STALL_EN
    span = len + ((len > 0) ? (len - 1) / 4 : 0);
`endif
    chk({tag, "_nreq"}, nreq, len);
    chk({tag, "_no_rd"}, nval, 0);
    if (len > 0) begin
      chk({tag, "_first"}, first, 2);
      chk({tag, "_span"}, last - first + 1, span);
      chk({tag, "_fin"}, fin, last + 1);
    end else begin
      chk({tag, "_fin"}, fin, 2);
    end
  endtask

  task automatic run_read(input logic [27:0] addr, input int len, input string tag);
    int cyc, first, last, fin, nval, nreq, a;
    cyc = 0; first = -1; last = -1; fin = -1; nval = 0; nreq = 0;
    a = int'(addr[9:0]);
    bus.rd_burst_addr = addr;
    bus.rd_burst_len  = 10'(len);
    bus.rd_burst_req  = 1'b1;
    for (int i = 0; i < len; i++) sb_q.push_back(model[(a + i) % 1024]);
    while (fin < 0 && cyc < 3000) begin
      @(negedge mem_clk);
      cyc++;
      if (cyc == 1) chk({tag, "_idle"}, bus.busy, 0);
      if (bus.wr_burst_data_req) nreq++;
      if (bus.rd_burst_data_valid) begin
        nval++;
        if (first < 0) first = cyc;
        last = cyc;
        if (sb_q.size() == 0) chk({tag, "_extra_beat"}, 1, 0);
        else chk({tag, "_data"}, bus.rd_burst_data, sb_q.pop_front());
      end
      if (bus.rd_burst_finish) begin
        fin = cyc;
        chk({tag, "_fin_excl"}, bus.rd_burst_data_valid, 0);
      end
      @(posedge mem_clk);
      #1;
    end
    bus.rd_burst_req = 1'b0;
    chk({tag, "_nval"}, nval, len);
    chk({tag, "_no_wr"}, nreq, 0);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
    sb_q.delete();
    if (len > 0) begin
      chk({tag, "_first"}, first, 3);
      chk({tag, "_span"}, last - first + 1, len);
      chk({tag, "_fin"}, fin, last + 1);
    end else begin
      chk({tag, "_fin"}, fin, 2);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_wr_req"}, bus.wr_burst_data_req, 0);
    chk({tag, "_wr_fin"}, bus.wr_burst_finish, 0);
    chk({tag, "_rd_valid"}, bus.rd_burst_data_valid, 0);
    chk({tag, "_rd_fin"}, bus.rd_burst_finish, 0);
    chk({tag, "_rd_data"}, bus.rd_burst_data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, k, hit, nfin, nbusy;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    rst = 1'b1;
    bus.wr_burst_req  = 1'b0;
    bus.wr_burst_len  = '0;
    bus.wr_burst_addr = '0;
    bus.wr_burst_data = '0;
    bus.rd_burst_req  = 1'b0;
    bus.rd_burst_len  = '0;
    bus.rd_burst_addr = '0;
    #3;
    chk_outputs_zero("por");
    @(posedge mem_clk);
    @(posedge mem_clk);
    #1 rst = 1'b0;

    // Basic write/read round trip
    run_write(28'h010, 4, 128'hA0, "w4");
    run_read (28'h010, 4, "r4");

    // Simultaneous requests: write first, read held pending
    bus.rd_burst_addr = 28'h020;
    bus.rd_burst_len  = 10'd2;
    bus.rd_burst_req  = 1'b1;
    run_write(28'h020, 2, 128'hB0, "wsim");
    run_read (28'h020, 2, "rsim");

    // Address wrap and ignored upper address bits
    run_write(28'h3FF, 3, 128'h0123_4567_89AB_CDEF_0000_0000_0000_00C0, "wwrap");
    run_read (28'h000, 2, "rwrap");
    run_read (28'hABC_0010, 4, "rhi");

    // Zero-length bursts
    run_write(28'h050, 0, 128'hEE, "w0");
    run_read (28'h050, 0, "r0");

    // Longer burst
    run_write(28'h200, 8, 128'hFACE_0000_0000_0000_0000_0000_0000_0010, "w8");
    run_read (28'h200, 8, "r8");

    // Reset during beat 2 of a len-8 write
    bus.wr_burst_addr = 28'h100;
    bus.wr_burst_len  = 10'd8;
    bus.wr_burst_data = 128'hD0;
    bus.wr_burst_req  = 1'b1;
    k = 0; cyc = 0; hit = 0;
    while (!hit && cyc < 50) begin
      @(negedge mem_clk);
      cyc++;
      if (bus.wr_burst_data_req && k == 2) begin
        hit = 1;
      end else begin
        if (bus.wr_burst_data_req) begin
          model[256 + k] = 128'hD0 + 128'(k);
          k++;
        end
        @(posedge mem_clk);
        #1;
        bus.wr_burst_data = 128'hD0 + 128'(k);
      end
    end
    chk("rst_reach_beat2", hit, 1);
    #2;
    rst = 1'b1;
    bus.wr_burst_req = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    @(posedge mem_clk);
    @(posedge mem_clk);
    #1 rst = 1'b0;
    nfin = 0; nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge mem_clk);
      if (bus.wr_burst_finish) nfin++;
      if (bus.busy) nbusy++;
      @(posedge mem_clk);
      #1;
    end
    chk("rst_no_finish", nfin, 0);
    chk("rst_stays_idle", nbusy, 0);
    run_read(28'h100, 2, "rrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 Parameter DDR_DATA_WIDTH, default 128, beat width in bits.
REQ-002 Parameter DDR_ADDR_WIDTH, default 28, burst address width in bits.
REQ-003 Parameter MEM_AW, default 10, internal storage address width; depth is 2**MEM_AW beats.
REQ-004 Port mem_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Ports wr_burst_req / rd_burst_req  input  1 each  level requests, held by initiator until the matching finish pulse.
REQ-007 Ports wr_burst_len / rd_burst_len  input  10 each  burst length in beats.
REQ-008 Ports wr_burst_addr / rd_burst_addr  input  DDR_ADDR_WIDTH each  start beat address.
REQ-009 Port wr_burst_data  input  DDR_DATA_WIDTH  write beat, valid in the cycle wr_burst_data_req is high.
REQ-010 Port wr_burst_data_req  output  1  responder accepts wr_burst_data this cycle.
REQ-011 Port rd_burst_data  output  DDR_DATA_WIDTH  read beat; rd_burst_data_valid  output  1  beat qualifier.
REQ-012 Ports wr_burst_finish / rd_burst_finish  output  1 each  single-cycle end-of-burst pulses.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, WR_BURST, WR_END, RD_ADDR, RD_BURST, RD_END.
REQ-015 IDLE: wr_burst_req high -> latch wr_burst_addr[MEM_AW-1:0], wr_burst_len, go WR_BURST; else rd_burst_req high -> latch read fields, go RD_ADDR; simultaneous requests: write wins, read remains pending.
REQ-016 Latched length 0: go directly to WR_END/RD_END; no data beats, finish pulse still issued.
REQ-017 WR_BURST: wr_burst_data_req high every cycle; each such cycle writes wr_burst_data at (start + beat_cnt) mod 2**MEM_AW and increments beat_cnt; after beat len-1 go WR_END.
REQ-018 WR_END: wr_burst_finish high one cycle; then IDLE.
REQ-019 RD_ADDR: issue synchronous read of first beat; RD_BURST issues one address per cycle for remaining beats.
REQ-020 Read latency: rd_burst_data_valid high exactly one cycle after each address issue; len consecutive valid cycles, data in ascending address order.
REQ-021 RD_END entered in the cycle after the last valid beat; rd_burst_finish high one cycle; then IDLE.
REQ-022 Address arithmetic: MEM_AW-bit, wraps silently at 2**MEM_AW; upper address bits ignored.
REQ-023 Requests arriving while busy are ignored until IDLE; initiator holding req through finish cycle does not retrigger, since IDLE samples only one cycle after the END state.
REQ-024 wr_burst_data_req, rd_burst_data_valid, both finish pulses never high simultaneously with each other except valid/finish never overlap by construction.
REQ-025 beat_cnt 10 bits; len up to 1023 supported.

Reset
REQ-026 rst asserted: state IDLE, beat_cnt 0, all outputs 0 (rd_burst_data 0) within the same cycle, asynchronously.
REQ-027 rst mid-burst: burst aborted, no finish pulse; storage contents retained (not cleared).
REQ-028 Release: first request sampled on first mem_clk edge after rst deasserts.

Configuration
REQ-029 Macro BURST_RESP_STALL_EN: when defined, WR_BURST deasserts wr_burst_data_req for one cycle after every 4th accepted beat (no write, beat_cnt held); when undefined, no stall cycles, REQ-017 timing exact.

Verification
REQ-030 Write len 4 addr 0x10 data 0xA0..0xA3 -> 4 consecutive req cycles, finish 1 cycle later; read len 4 addr 0x10 -> 4 valid beats 0xA0..0xA3, finish next cycle.
REQ-031 Simultaneous wr_burst_req (len 2) and rd_burst_req (len 2) -> write completes first, read starts after IDLE and returns written data.
REQ-032 Write len 3 at addr 0x3FF (MEM_AW 10) -> beats at 0x3FF, 0x000, 0x001; read back from 0x000 returns beats 2,3.
REQ-033 Len 0 write and read -> no req/valid cycles, finish pulse 1 cycle after leaving IDLE.
REQ-034 rst high during beat 2 of len-8 write -> outputs 0 immediately, no finish; later read of beats 0-1 returns written data.
REQ-035 With BURST_RESP_STALL_EN, write len 8 -> req pattern 1111 0 1111, 8 beats stored, finish after 9 req-phase cycles.
